// File: rtl/fft2d_transposer.sv
// -----------------------------------------------------------------------------
// fft2d_transposer
//
// Moves an N x N matrix (N = 2**LOG_N) from the row-FFT result bank to the
// column-FFT input bank. The source is read row-major. Element {r, c} is
// written to destination address {c', r}. c' is c, or c bit-reversed when
// do_bitreversing was high at start.
//
// Ports
//   extc_base_clock   system clock, rising edge
//   extc_asyn_reset   asynchronous active-high reset
//   transposer_reset  synchronous active-high soft reset; wins in every state
//   do_transpose      level start request, honoured only in IDLE
//   do_bitreversing   bit-reverse destination column index, sampled at start
//   done_transpose    sticky completion flag, cleared by either reset
//   busy              high in RUN and DRAIN
//   rd_en / rd_addr   source RAM read port, rd_addr = {row, col}
//   rd_data           source RAM data, valid RD_LAT cycles after rd_en
//   wr_en / wr_addr / wr_data  destination RAM write port
//   fsm_state         debug view of the controller state
//
// Handshake: no back-pressure. Every cycle rd_en is high, one read is
// issued. Exactly RD_LAT cycles later, wr_en is high for one cycle and
// carries that read's data.
// -----------------------------------------------------------------------------
module fft2d_transposer #(
  parameter int LOG_N  = 5,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                 extc_base_clock,
  input  logic                 extc_asyn_reset,
  input  logic                 transposer_reset,
  input  logic                 do_transpose,
  input  logic                 do_bitreversing,
  output logic                 done_transpose,
  output logic                 busy,
  output logic                 rd_en,
  output logic [2*LOG_N-1:0]   rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 wr_en,
  output logic [2*LOG_N-1:0]   wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [1:0]           fsm_state
);

  localparam int AW = 2 * LOG_N;
  localparam logic [AW-1:0] K_LAST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                     state, state_nx;
  logic [AW-1:0]              k;
  logic                       br_q;
  logic [LOG_N-1:0]           col, col_rev, col_sel;
  logic [LOG_N-1:0]           row;
  logic [RD_LAT-1:0]          vld_sr;
  logic [RD_LAT-1:0][AW-1:0]  addr_sr;

  // State register
  always_ff @(posedge extc_base_clock or posedge extc_asyn_reset) begin
    if (extc_asyn_reset) state <= IDLE;
    else                 state <= state_nx;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nx       = state;
    rd_en          = 1'b0;
    busy           = 1'b0;
    done_transpose = 1'b0;
    if (transposer_reset) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (do_transpose) state_nx = RUN;
        RUN:     if (k == K_LAST)  state_nx = DRAIN;
        // Leave only once the last delayed write has left the pipeline.
        DRAIN:   if (vld_sr == '0) state_nx = DONE;
        default: state_nx = state;
      endcase
    end
    case (state)
      RUN:     begin rd_en = 1'b1; busy = 1'b1; end
      DRAIN:   busy = 1'b1;
      DONE:    done_transpose = 1'b1;
      default: ;
    endcase
  end

  // Read counter and latched bit-reverse mode
  always_ff @(posedge extc_base_clock or posedge extc_asyn_reset) begin
    if (extc_asyn_reset) begin
      k    <= '0;
      br_q <= 1'b0;
    end else if (transposer_reset) begin
      k    <= '0;
      br_q <= 1'b0;
    end else if (state == IDLE && do_transpose) begin
      k    <= '0;
      br_q <= do_bitreversing;
    end else if (state == RUN) begin
      // Wraps to 0 exactly on the last read.
      k <= k + 1'b1;
    end
  end

  // Destination address for the read being issued now
  always_comb begin
    row = k[AW-1:LOG_N];
    col = k[LOG_N-1:0];
    col_rev = '0;
    for (int i = 0; i < LOG_N; i++) col_rev[i] = col[LOG_N-1-i];
    col_sel = br_q ? col_rev : col;
  end

  // Delay line keeping write address/valid aligned with rd_data
  always_ff @(posedge extc_base_clock or posedge extc_asyn_reset) begin
    if (extc_asyn_reset) begin
      vld_sr  <= '0;
      addr_sr <= '0;
    end else if (transposer_reset) begin
      vld_sr  <= '0;
      addr_sr <= '0;
    end else begin
      vld_sr[0]  <= rd_en;
      addr_sr[0] <= {col_sel, row};
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
      end
    end
  end

  assign rd_addr   = k;
  assign wr_en     = vld_sr[RD_LAT-1];
  assign wr_addr   = addr_sr[RD_LAT-1];
  // Gated so the port reads 0 whenever no write is presented.
  assign wr_data   = wr_en ? rd_data : '0;
  assign fsm_state = state;

endmodule

// File: tb/tb_fft2d_transposer.sv
// -----------------------------------------------------------------------------
// tb_fft2d_transposer
// Two instances share clock, resets and controls: dut1 (RD_LAT=1) and
// dut3 (RD_LAT=3). Each source RAM holds source[k] = k. When a transfer is
// started, the expected {wr_addr, wr_data} sequence is pushed per instance.
// A negedge monitor pops and compares on every wr_en.
// -----------------------------------------------------------------------------
module tb_fft2d_transposer;
  localparam int LOG_N = 5;
  localparam int N     = 32;
  localparam int NN    = N * N;
  localparam int AW    = 2 * LOG_N;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic arst = 1'b0;
  logic soft_rst = 1'b0;
  logic do_tr = 1'b0;
  logic do_br = 1'b0;

  logic          done1, busy1, rd_en1, wr_en1;
  logic [AW-1:0] rd_addr1, wr_addr1;
  logic [DW-1:0] rd_data1, wr_data1;
  logic [1:0]    st1;
  logic          done3, busy3, rd_en3, wr_en3;
  logic [AW-1:0] rd_addr3, wr_addr3;
  logic [DW-1:0] rd_data3, wr_data3, d3_a, d3_b;
  logic [1:0]    st3;

  logic [AW+DW-1:0] exp_q1[$];
  logic [AW+DW-1:0] exp_q3[$];
  int            seen1[NN];
  int            seen3[NN];
  logic [DW-1:0] dst1[NN];
  logic [DW-1:0] dst3[NN];
  int n_cmp = 0;
  int n_err = 0;

  fft2d_transposer #(.LOG_N(LOG_N), .DATA_W(DW), .RD_LAT(1)) dut1 (
    .extc_base_clock(clk), .extc_asyn_reset(arst), .transposer_reset(soft_rst),
    .do_transpose(do_tr), .do_bitreversing(do_br), .done_transpose(done1),
    .busy(busy1), .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .fsm_state(st1));

  fft2d_transposer #(.LOG_N(LOG_N), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .extc_base_clock(clk), .extc_asyn_reset(arst), .transposer_reset(soft_rst),
    .do_transpose(do_tr), .do_bitreversing(do_br), .done_transpose(done3),
    .busy(busy3), .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3), .fsm_state(st3));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- source RAM models (source[k] = k) ----------------
  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= {{(DW-AW){1'b0}}, rd_addr1};
    if (rd_en3) d3_a <= {{(DW-AW){1'b0}}, rd_addr3};
    d3_b     <= d3_a;
    rd_data3 <= d3_b;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] rev5(input logic [4:0] c);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r = {r[3:0], c[i]};
    return r;
  endfunction

  // Push the expected write sequence for one full transfer into both queues.
  task automatic push_expected(input logic br);
    logic [4:0]    r, c, cx;
    logic [AW-1:0] a;
    for (int kk = 0; kk < NN; kk++) begin
      r  = kk[9:5];
      c  = kk[4:0];
      cx = br ? rev5(c) : c;
      a  = {cx, r};
      exp_q1.push_back({a, DW'(kk)});
      exp_q3.push_back({a, DW'(kk)});
    end
    for (int i = 0; i < NN; i++) begin
      seen1[i] = 0; seen3[i] = 0; dst1[i] = 'x; dst3[i] = 'x;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!arst) begin
      if (wr_en1) begin
        if (exp_q1.size() == 0) chk("dut1_unexpected_write", 64'(wr_addr1), 64'h3ff_ffff_ffff);
        else chk("dut1_write", 64'({wr_addr1, wr_data1}), 64'(exp_q1.pop_front()));
        seen1[wr_addr1]++;
        dst1[wr_addr1] = wr_data1;
      end
      if (wr_en3) begin
        if (exp_q3.size() == 0) chk("dut3_unexpected_write", 64'(wr_addr3), 64'h3ff_ffff_ffff);
        else chk("dut3_write", 64'({wr_addr3, wr_data3}), 64'(exp_q3.pop_front()));
        seen3[wr_addr3]++;
        dst3[wr_addr3] = wr_data3;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    arst = 1'b1;
    #12;
    chk("reset_done", 64'({done1, done3}), 64'd0);
    chk("reset_busy", 64'({busy1, busy3}), 64'd0);
    chk("reset_rd_en", 64'({rd_en1, rd_en3}), 64'd0);
    chk("reset_wr_en", 64'({wr_en1, wr_en3}), 64'd0);
    chk("reset_addrs", 64'({rd_addr1, wr_addr1, rd_addr3, wr_addr3}), 64'd0);
    chk("reset_state", 64'({st1, st3}), 64'd0);
    @(negedge clk);
    arst = 1'b0;
  endtask

  // Drive the start request; returns right after the accepting edge (edge 0).
  task automatic begin_run(input logic br);
    @(negedge clk);
    do_br = br;
    do_tr = 1'b1;
    push_expected(br);
    @(posedge clk);
  endtask

  // Check one instance's per-cycle timing t cycles after edge 0.
  task automatic chk_timing(input string tag, input int t, input int lat,
                            input logic re, input logic [AW-1:0] ra, input logic we,
                            input logic bz, input logic dn);
    chk($sformatf("%s_rd_en t=%0d", tag, t), 64'(re), 64'(t < NN));
    if (t < NN) chk($sformatf("%s_rd_addr t=%0d", tag, t), 64'(ra), 64'(t));
    chk($sformatf("%s_wr_en t=%0d", tag, t), 64'(we), 64'(t >= lat && t <= NN - 1 + lat));
    chk($sformatf("%s_busy t=%0d", tag, t), 64'(bz), 64'(t <= NN + lat));
    chk($sformatf("%s_done t=%0d", tag, t), 64'(dn), 64'(t >= NN + lat + 1));
  endtask

  // Full transfer with cycle-exact timing checks.
  task automatic run_full(input logic br, input bit disturb);
    begin_run(br);
    for (int t = 0; t <= NN + 6; t++) begin
      @(negedge clk);
      chk_timing("dut1", t, 1, rd_en1, rd_addr1, wr_en1, busy1, done1);
      chk_timing("dut3", t, 3, rd_en3, rd_addr3, wr_en3, busy3, done3);
      if (disturb && t == 5)  do_br = ~br;
      if (disturb && t == 10) do_tr = 1'b0;
    end
    chk("dut1_queue_empty", 64'(exp_q1.size()), 64'd0);
    chk("dut3_queue_empty", 64'(exp_q3.size()), 64'd0);
    begin
      int bad1, bad3;
      bad1 = 0; bad3 = 0;
      for (int i = 0; i < NN; i++) begin
        if (seen1[i] != 1) bad1++;
        if (seen3[i] != 1) bad3++;
      end
      chk("dut1_each_addr_once", 64'(bad1), 64'd0);
      chk("dut3_each_addr_once", 64'(bad3), 64'd0);
    end
  endtask

  // Stay in DONE a while (do_transpose possibly still high), then soft reset.
  task automatic hold_and_clear();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_rd_en", 64'({rd_en1, rd_en3}), 64'd0);
      chk("hold_done", 64'({done1, done3}), 64'h3);
    end
    soft_rst = 1'b1;
    do_tr = 1'b0;
    @(negedge clk);
    chk("clear_done", 64'({done1, done3}), 64'd0);
    chk("clear_busy", 64'({busy1, busy3}), 64'd0);
    soft_rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, summary forced");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    reset_dut();

    // Plain transpose, do_transpose held high through DONE.
    run_full(1'b0, 1'b0);
    chk("dut1_cell_01F", 64'(dst1[10'h01F]), 64'h3E0);
    chk("dut3_cell_01F", 64'(dst3[10'h01F]), 64'h3E0);
    chk("dut1_cell_3E0", 64'(dst1[10'h3E0]), 64'h01F);
    hold_and_clear();

    // Bit-reversed columns; controls disturbed mid-run.
    run_full(1'b1, 1'b1);
    chk("dut1_cell_203", 64'(dst1[10'h203]), 64'h061);
    chk("dut3_cell_203", 64'(dst3[10'h203]), 64'h061);
    chk("dut1_cell_000", 64'(dst1[10'h000]), 64'h000);
    chk("dut1_cell_3FF", 64'(dst1[10'h3FF]), 64'h3FF);
    hold_and_clear();

    // Soft abort in the middle of RUN.
    begin_run(1'b0);
    repeat (500) @(negedge clk);
    soft_rst = 1'b1;
    do_tr = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_rd_en", 64'({rd_en1, rd_en3}), 64'd0);
      chk("abort_wr_en", 64'({wr_en1, wr_en3}), 64'd0);
      chk("abort_done", 64'({done1, done3}), 64'd0);
      chk("abort_busy", 64'({busy1, busy3}), 64'd0);
    end
    soft_rst = 1'b0;
    exp_q1.delete();
    exp_q3.delete();
    // Restart must begin from k = 0 (rd_addr checked every cycle).
    run_full(1'b0, 1'b0);
    hold_and_clear();

    // Asynchronous reset between clock edges mid-transfer.
    begin_run(1'b1);
    repeat (300) @(negedge clk);
    @(posedge clk);
    #2 arst = 1'b1;
    #1;
    chk("arst_rd_en", 64'({rd_en1, rd_en3}), 64'd0);
    chk("arst_wr_en", 64'({wr_en1, wr_en3}), 64'd0);
    chk("arst_busy", 64'({busy1, busy3}), 64'd0);
    chk("arst_done", 64'({done1, done3}), 64'd0);
    chk("arst_rd_addr", 64'({rd_addr1, rd_addr3}), 64'd0);
    chk("arst_wr_addr", 64'({wr_addr1, wr_addr3}), 64'd0);
    chk("arst_wr_data", 64'({wr_data1, wr_data3}), 64'd0);
    @(negedge clk);
    do_tr = 1'b0;
    arst = 1'b0;
    exp_q1.delete();
    exp_q3.delete();
    repeat (2) @(negedge clk);
    chk("post_arst_idle", 64'({busy1, busy3, rd_en1, rd_en3}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
